// File: rtl/zstr_snk.sv
// Stream sink for a zstr source: ready pattern generator plus circular capture queue with status.
// q_dat shows a pushed head entry one edge after the push; z_rdy depends only on registered state and cfg_mode.
module zstr_snk #(
   parameter int              BW   = 1,
   parameter logic [BW-1:0]   XZ   = 'x,
   parameter int              QL   = 16,
   parameter int              QW   = $clog2(QL),
   parameter bit              BLK  = 1'b1,
   parameter logic [15:0]     SEED = 16'hACE1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          z_vld,
   input  logic [BW-1:0] z_bus,
   output logic          z_rdy,
   input  logic [1:0]    cfg_mode,
   input  logic [7:0]    cfg_per,
   input  logic          q_rd,
   output logic [BW-1:0] q_dat,
   output logic [QW:0]   q_cnt,
   output logic [31:0]   trn_cnt,
   output logic          ovf,
   output logic          udf
);

   logic [BW-1:0] mem [QL];
   logic [QW-1:0] wp;
   logic [QW-1:0] rp;
   logic [7:0]    per_cnt;
   logic [15:0]   lfsr;
   logic          pat;
   logic          full;
   logic          empty;
   logic          z_trn;
   logic          push;
   logic          pop;

   always_comb begin
      pat = 1'b1;
      case (cfg_mode)
         2'd1:    pat = 1'b0;
         2'd2:    pat = (per_cnt == 8'd0);
         2'd3:    pat = lfsr[0];
         default: pat = 1'b1;
      endcase
   end

   assign full  = (q_cnt == (QW+1)'(QL));
   assign empty = (q_cnt == '0);
   // Full is judged from the start-of-cycle count, so a same-cycle pop never makes room.
   assign z_rdy = pat & (~full | ~BLK);
   assign z_trn = z_vld & z_rdy;
   assign push  = z_trn & ~full;
   assign pop   = q_rd & ~empty;
   assign q_dat = empty ? XZ : mem[rp];

   always_ff @(posedge clk) begin
      if (push && !rst) begin
         mem[wp] <= z_bus;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wp      <= '0;
         rp      <= '0;
         q_cnt   <= '0;
         trn_cnt <= '0;
         ovf     <= 1'b0;
         udf     <= 1'b0;
         per_cnt <= '0;
         lfsr    <= SEED;
      end else begin
         // Galois form of x^16+x^14+x^13+x^11+1, free-running in every mode.
         lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

         if (cfg_mode != 2'd2 || per_cnt >= cfg_per) begin
            per_cnt <= '0;
         end else begin
            per_cnt <= per_cnt + 8'd1;
         end

         if (push) begin
            wp <= (wp == QW'(QL-1)) ? '0 : wp + 1'b1;
         end
         if (pop) begin
            rp <= (rp == QW'(QL-1)) ? '0 : rp + 1'b1;
         end

         case ({push, pop})
            2'b10:   q_cnt <= q_cnt + 1'b1;
            2'b01:   q_cnt <= q_cnt - 1'b1;
            default: q_cnt <= q_cnt;
         endcase

         if (z_trn) begin
            trn_cnt <= trn_cnt + 32'd1;
         end
         if (z_trn && full) begin
            ovf <= 1'b1;
         end
         if (q_rd && empty) begin
            udf <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_zstr_snk.sv
// Directed bench for zstr_snk: a blocking (BLK=1) and a dropping (BLK=0) instance share stimulus.
module tb_zstr_snk;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        z_vld = 1'b0;
   logic [7:0]  z_bus = 8'h00;
   logic [1:0]  cfg_mode = 2'd0;
   logic [7:0]  cfg_per = 8'd0;
   logic        q_rd = 1'b0;

   logic        z_rdy_a, z_rdy_b;
   logic [7:0]  q_dat_a, q_dat_b;
   logic [2:0]  q_cnt_a, q_cnt_b;
   logic [31:0] trn_a, trn_b;
   logic        ovf_a, ovf_b, udf_a, udf_b;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   zstr_snk #(.BW(8), .XZ(8'hEE), .QL(4), .BLK(1'b1), .SEED(16'hACE1)) dut_a (
      .clk(clk), .rst(rst), .z_vld(z_vld), .z_bus(z_bus), .z_rdy(z_rdy_a),
      .cfg_mode(cfg_mode), .cfg_per(cfg_per), .q_rd(q_rd), .q_dat(q_dat_a),
      .q_cnt(q_cnt_a), .trn_cnt(trn_a), .ovf(ovf_a), .udf(udf_a)
   );

   zstr_snk #(.BW(8), .XZ(8'hEE), .QL(4), .BLK(1'b0), .SEED(16'hACE1)) dut_b (
      .clk(clk), .rst(rst), .z_vld(z_vld), .z_bus(z_bus), .z_rdy(z_rdy_b),
      .cfg_mode(cfg_mode), .cfg_per(cfg_per), .q_rd(q_rd), .q_dat(q_dat_b),
      .q_cnt(q_cnt_b), .trn_cnt(trn_b), .ovf(ovf_b), .udf(udf_b)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      z_vld = 1'b0;
      q_rd = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   logic [15:0] m;
   logic [7:0]  wq [500];
   int got, nw, last, wi, rj;

   initial begin
      // Mode 0 basic push/pop
      cfg_mode = 2'd0;
      do_reset();
      chk("rst_cnt", 32'(q_cnt_a), 0);
      chk("rst_trn", trn_a, 0);
      chk("rst_ovf", 32'(ovf_a), 0);
      chk("rst_udf", 32'(udf_a), 0);
      chk("rst_qdat", 32'(q_dat_a), 32'hEE);
      chk("rst_rdy", 32'(z_rdy_a), 1);
      for (int i = 1; i <= 3; i++) begin
         z_vld = 1'b1;
         z_bus = 8'(i);
         chk("t1_rdy", 32'(z_rdy_a), 1);
         @(negedge clk);
      end
      z_vld = 1'b0;
      chk("t1_cnt", 32'(q_cnt_a), 3);
      chk("t1_trn", trn_a, 3);
      for (int i = 1; i <= 3; i++) begin
         chk("t1_pop", 32'(q_dat_a), 32'(i));
         q_rd = 1'b1;
         @(negedge clk);
      end
      q_rd = 1'b0;
      chk("t1_empty_dat", 32'(q_dat_a), 32'hEE);
      chk("t1_empty_cnt", 32'(q_cnt_a), 0);
      chk("t1_udf", 32'(udf_a), 0);

      // Full gating on the blocking instance
      do_reset();
      for (int i = 1; i <= 4; i++) begin
         z_vld = 1'b1;
         z_bus = 8'(i);
         @(negedge clk);
      end
      z_bus = 8'd5;
      chk("t2_rdy_low", 32'(z_rdy_a), 0);
      chk("t2_cnt_full", 32'(q_cnt_a), 4);
      chk("t2_ovf", 32'(ovf_a), 0);
      @(negedge clk);
      chk("t2_hold_rdy", 32'(z_rdy_a), 0);
      chk("t2_hold_trn", trn_a, 4);
      q_rd = 1'b1;
      @(negedge clk);
      q_rd = 1'b0;
      chk("t2_pop_cnt", 32'(q_cnt_a), 3);
      chk("t2_rdy_back", 32'(z_rdy_a), 1);
      @(negedge clk);
      z_vld = 1'b0;
      chk("t2_w5_cnt", 32'(q_cnt_a), 4);
      chk("t2_w5_trn", trn_a, 5);
      chk("t2_head", 32'(q_dat_a), 2);

      // Overflow on the dropping instance
      do_reset();
      for (int i = 1; i <= 6; i++) begin
         z_vld = 1'b1;
         z_bus = 8'(i);
         @(negedge clk);
      end
      z_vld = 1'b0;
      chk("t3_trn", trn_b, 6);
      chk("t3_cnt", 32'(q_cnt_b), 4);
      chk("t3_ovf", 32'(ovf_b), 1);
      for (int i = 1; i <= 4; i++) begin
         chk("t3_pop", 32'(q_dat_b), 32'(i));
         q_rd = 1'b1;
         @(negedge clk);
      end
      q_rd = 1'b0;
      chk("t3_drained", 32'(q_cnt_b), 0);

      // Periodic mode, cfg_per=3
      cfg_mode = 2'd2;
      cfg_per = 8'd3;
      do_reset();
      for (int c = 0; c < 8; c++) begin
         chk("t4_pat", 32'(z_rdy_a), (c % 4 == 0) ? 1 : 0);
         @(negedge clk);
      end
      got = 0; nw = 0; last = -1;
      for (int c = 0; c < 100 && got < 8; c++) begin
         z_vld = (nw < 8);
         z_bus = 8'h10 + 8'(nw);
         q_rd = 1'b0;
         if (q_cnt_a != 0) begin
            chk("t4_dat", 32'(q_dat_a), 32'h10 + 32'(got));
            got++;
            q_rd = 1'b1;
         end
         if (z_vld && z_rdy_a) begin
            nw++;
            if (nw == 8) last = c + 1;
         end
         @(negedge clk);
      end
      z_vld = 1'b0;
      q_rd = 1'b0;
      chk("t4_got", 32'(got), 8);
      chk("t4_cycles", 32'(last), 29);
      cfg_mode = 2'd1;
      z_vld = 1'b1;
      repeat (20) @(negedge clk);
      z_vld = 1'b0;
      chk("t4_never_trn", trn_a, 8);

      // Random mode: LFSR reference and in-order delivery
      cfg_mode = 2'd3;
      do_reset();
      m = 16'hACE1;
      for (int c = 0; c < 1000; c++) begin
         chk("t5_lfsr", 32'(z_rdy_a), 32'(m[0]));
         m = {1'b0, m[15:1]} ^ (m[0] ? 16'hB400 : 16'h0000);
         @(negedge clk);
      end
      for (int k = 0; k < 500; k++) wq[k] = 8'($urandom);
      wi = 0; rj = 0;
      for (int c = 0; c < 20000 && rj < 500; c++) begin
         z_vld = (wi < 500) && ($urandom_range(0, 3) != 0);
         z_bus = (wi < 500) ? wq[wi] : 8'h00;
         q_rd = 1'($urandom_range(0, 1));
         if (q_rd && q_cnt_a != 0) begin
            chk("t5_dat", 32'(q_dat_a), 32'(wq[rj]));
            rj++;
         end
         if (z_vld && z_rdy_a) wi++;
         @(negedge clk);
      end
      z_vld = 1'b0;
      q_rd = 1'b0;
      chk("t5_all_popped", 32'(rj), 500);
      chk("t5_cnt", 32'(q_cnt_a), 0);

      // Corners
      cfg_mode = 2'd0;
      do_reset();
      q_rd = 1'b1;
      @(negedge clk);
      q_rd = 1'b0;
      chk("t6_udf", 32'(udf_a), 1);
      chk("t6_udf_cnt", 32'(q_cnt_a), 0);
      for (int i = 1; i <= 2; i++) begin
         z_vld = 1'b1;
         z_bus = 8'h20 + 8'(i);
         @(negedge clk);
      end
      z_bus = 8'h23;
      q_rd = 1'b1;
      @(negedge clk);
      z_vld = 1'b0;
      q_rd = 1'b0;
      chk("t6_pp_cnt", 32'(q_cnt_a), 2);
      chk("t6_pp_head", 32'(q_dat_a), 32'h22);
      chk("t6_pp_trn", trn_a, 3);
      z_vld = 1'b1;
      z_bus = 8'h24;
      @(negedge clk);
      chk("t6_cnt3", 32'(q_cnt_a), 3);
      rst = 1'b1;
      z_bus = 8'h25;
      @(negedge clk);
      rst = 1'b0;
      z_vld = 1'b0;
      chk("t6_rst_cnt", 32'(q_cnt_a), 0);
      chk("t6_rst_trn", trn_a, 0);
      chk("t6_rst_ovf", 32'(ovf_a), 0);
      chk("t6_rst_udf", 32'(udf_a), 0);
      chk("t6_rst_dat", 32'(q_dat_a), 32'hEE);
      q_rd = 1'b1;
      z_vld = 1'b1;
      z_bus = 8'h31;
      @(negedge clk);
      q_rd = 1'b0;
      z_vld = 1'b0;
      chk("t6_ep_cnt", 32'(q_cnt_a), 1);
      chk("t6_ep_udf", 32'(udf_a), 1);
      chk("t6_ep_dat", 32'(q_dat_a), 32'h31);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/zstr_snk.md
Name: zstr_snk

Overview:
- Stream sink that sits directly downstream of a zstr source and consumes its z stream.
- Generates z_rdy backpressure from a selectable pattern: always, never, periodic or pseudo-random.
- Captures every accepted transfer into a circular queue that the bench/checker pops through a simple read port.
- Provides transfer, overflow and underflow status for scoreboarding.

Parameters:
BW, 1, stream bus width in bits
XZ, 1'bx, value driven on q_dat while queue empty
QL, 16, queue length in entries (any value >= 2)
QW, $clog2(QL), queue pointer width
BLK, 1, 1 = z_rdy gated off while queue full; 0 = never gated, excess data dropped
SEED, 16'hACE1, LFSR reset value (must be non-zero)

Ports:
clk      input   1        system clock
rst      input   1        synchronous reset, active high
z_vld    input   1        transfer valid
z_bus    input   BW       grouped bus signals
z_rdy    output  1        transfer ready
cfg_mode input   2        ready pattern: 0 always, 1 never, 2 periodic, 3 random
cfg_per  input   8        periodic mode: z_rdy high 1 of every cfg_per+1 cycles
q_rd     input   1        pop head of queue
q_dat    output  BW       head of queue (XZ when empty)
q_cnt    output  QW+1     entries currently in queue
trn_cnt  output  32       total accepted transfers, wraps mod 2^32
ovf      output  1        sticky: transfer accepted while full (BLK=0 only)
udf      output  1        sticky: q_rd while empty

Behaviour:
- Clock and reset: single clock domain. All state updates on posedge clk. rst is sampled synchronously and has priority over all other activity in that cycle.
- Reset values: q_cnt=0, write/read pointers=0, trn_cnt=0, ovf=0, udf=0, period counter=0, lfsr=SEED.
- z_rdy after reset follows cfg_mode combinationally: 1 in mode 0, 0 in mode 1, 1 in mode 2 (counter=0), SEED[0] in mode 3.
- Transfer: z_trn = z_vld & z_rdy in the same cycle. There is no combinational path from z_vld or q_rd to z_rdy; z_rdy depends only on registered state and cfg_mode.
- Ready pattern pat:
  - mode 0: pat=1.
  - mode 1: pat=0.
  - mode 2: period counter counts 0..cfg_per and wraps to 0; pat=(counter==0). The counter is held at 0 whenever mode!=2. cfg_per=0 gives pat=1 every cycle. A cfg_per change takes effect when the counter next reaches or exceeds it; counter >= cfg_per wraps to 0.
  - mode 3: 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1, advancing every cycle regardless of mode; pat=lfsr[0].
- Ready gating: BLK=1 gives z_rdy = pat & (q_cnt<QL); BLK=0 gives z_rdy = pat.
- Push: on z_trn with q_cnt<QL, z_bus is written at the write pointer, the pointer advances (wrapping QL-1 -> 0), q_cnt increments and trn_cnt increments.
- Push when full (BLK=0): on z_trn with q_cnt==QL, data is dropped, ovf is set, trn_cnt still increments, and pointers and q_cnt are unchanged. Full is judged at the start of the cycle; a same-cycle pop does not make room.
- Pop: q_rd with q_cnt>0 advances the read pointer (wrapping) and decrements q_cnt. q_rd with q_cnt==0 sets udf and changes nothing else.
- Simultaneous push and pop with 0<q_cnt<QL: q_cnt is unchanged and both pointers advance.
- Empty-queue pop plus push in the same cycle: the push is taken, udf is set, and q_cnt becomes 1.
- q_dat: combinational buf[read pointer] when q_cnt>0, else XZ. Zero latency from push to visibility: an entry pushed at edge N is on q_dat after edge N if it is at the head.
- Reset mid-operation: queue contents are discarded logically (counters and pointers cleared). RAM contents need not be cleared. A transfer coincident with rst is not captured and not counted.
- Sticky flags: ovf and udf clear only on rst.

Test Plan:
- Mode 0, BLK=1, QL=4: source sends 0x1,0x2,0x3 back-to-back with no pops -> z_rdy stays 1, q_cnt=3, trn_cnt=3; then pop 3 times -> q_dat reads 0x1,0x2,0x3 in order, then XZ, q_cnt=0.
- Full gating, BLK=1, QL=4: send 6 words with no pops -> z_rdy falls the cycle after the 4th push, q_cnt=4, ovf=0, source holds word 5; one pop -> z_rdy returns next cycle and word 5 is accepted.
- Overflow, BLK=0, QL=4: send 6 words with no pops -> trn_cnt=6, q_cnt=4, ovf=1, queue holds words 1-4.
- Mode 2, cfg_per=3, z_vld constant: z_rdy pattern 1,0,0,0,1,0,0,0; 8 words take 29 cycles and arrive in order. Mode 1 for 20 cycles -> trn_cnt unchanged.
- Mode 3 after reset: z_rdy sequence matches a reference LFSR model seeded 0xACE1 for 1000 cycles. 500 random words all arrive in order with no loss under random q_rd.
- Corners: q_rd on empty -> udf=1, q_cnt=0. Simultaneous push and pop at q_cnt=2 -> q_cnt=2. rst asserted with z_vld=1 and queue at 3 -> next cycle q_cnt=0, trn_cnt=0, ovf=0, udf=0, q_dat=XZ.
